// File: rtl/elelock_pkg.sv
// Shared types and helpers for the multi-digit electronic lock.
// The optional secret re-programming feature is enabled by ELELOCK_PROG_EN.
package elelock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_e;

  typedef logic [3:0] digit_t;

  typedef struct packed {
    logic   vld;
    digit_t digit;
  } key_t;

  // One-hot keypad value to digit; vld only when exactly one key is down
  function automatic key_t keyenc(input logic [9:0] tk);
    key_t        k;
    int unsigned ones;
    k    = '0;
    ones = 0;
    for (int i = 0; i < 10; i++) begin
      if (tk[i]) begin
        ones    = ones + 1;
        k.digit = digit_t'(i);
      end
    end
    k.vld = (ones == 1);
    return k;
  endfunction

endpackage

// File: rtl/elelock_keyin.sv
// Keypad front end: detects a fresh single-key press (all keys up on the
// previous sample) and presents it, encoded, one cycle later.
module elelock_keyin
  import elelock_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] tenkey,
  output logic       press_vld,
  output digit_t     press_digit
);

  logic [9:0] tk_prev_q;
  logic       vld_q;
  logic       vld_d;
  digit_t     dig_q;
  key_t       key;

  assign key   = keyenc(tenkey);
  assign vld_d = key.vld && (tk_prev_q == '0);

  // Previous keypad sample; reset marks every key as held so a key that is
  // already down when reset releases must be let go before it counts
  always_ff @(posedge clk) begin
    if (reset) tk_prev_q <= '1;
    else       tk_prev_q <= tenkey;
  end

  // Press strobe register
  always_ff @(posedge clk) begin
    if (reset) vld_q <= 1'b0;
    else       vld_q <= vld_d;
  end

  // Encoded digit travels alongside the strobe
  always_ff @(posedge clk) begin
    dig_q <= key.digit;
  end

  assign press_vld   = vld_q;
  assign press_digit = dig_q;

endmodule

// File: rtl/elelock_multi.sv
// Parametrised electronic lock: DIGITS-long entry buffer, compare on enter,
// consecutive-failure lockout. Define ELELOCK_PROG_EN to add the prog port
// and a writable secret register.
module elelock_multi
  import elelock_pkg::*;
#(
  parameter int                  DIGITS         = 4,
  parameter logic [4*DIGITS-1:0] SECRET         = 16'h5963,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  LOCKOUT_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [9:0]                  tenkey,
  input  logic                        enter,
  input  logic                        close,
`ifdef ELELOCK_PROG_EN
  input  logic                        prog,
`endif
  output logic                        lock,
  output logic                        err,
  output logic                        locked_out,
  output logic [$clog2(DIGITS+1)-1:0] digit_cnt
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [CW-1:0] CNT_FULL  = CW'(DIGITS);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);
  localparam logic [LW-1:0] LOCK_LAST = LW'(1);

  state_e        state_q, state_d;
  logic [BW-1:0] code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          err_q, err_d;
  logic [BW-1:0] secret_w;
  logic [BW-1:0] code_shift;
  logic [CW-1:0] cnt_inc;
  logic          press_vld;
  digit_t        press_digit;

  elelock_keyin u_keyin (
    .clk         (clk),
    .reset       (reset),
    .tenkey      (tenkey),
    .press_vld   (press_vld),
    .press_digit (press_digit)
  );

`ifdef ELELOCK_PROG_EN
  logic [BW-1:0] secret_q, secret_d;
  assign secret_w = secret_q;
`else
  assign secret_w = SECRET;
`endif

  // Newest digit enters the low nibble; count saturates at a full buffer
  assign code_shift = (code_q << 4) | BW'(press_digit);
  assign cnt_inc    = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;

  // Next-state logic; priority within a cycle is close > prog > enter > press
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    lcnt_d  = lcnt_q;
    err_d   = 1'b0;
`ifdef ELELOCK_PROG_EN
    secret_d = secret_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (close) begin
          code_d = '0;
          cnt_d  = '0;
        end else if (enter) begin
          code_d = '0;
          cnt_d  = '0;
          if ((cnt_q == CNT_FULL) && (code_q == secret_w)) begin
            state_d = ST_OPEN;
            fail_d  = '0;
          end else begin
            err_d  = 1'b1;
            fail_d = fail_q + 1'b1;
            if (fail_d == FAIL_MAX) begin
              state_d = ST_LOCKOUT;
              lcnt_d  = LOCK_LOAD;
            end
          end
        end else if (press_vld) begin
          code_d = code_shift;
          cnt_d  = cnt_inc;
        end
      end
      ST_OPEN: begin
        if (close) begin
          state_d = ST_IDLE;
          code_d  = '0;
          cnt_d   = '0;
        end
`ifdef ELELOCK_PROG_EN
        else if (prog) begin
          if (cnt_q == CNT_FULL) secret_d = code_q;
          code_d = '0;
          cnt_d  = '0;
        end
`endif
        else if (!enter && press_vld) begin
          code_d = code_shift;
          cnt_d  = cnt_inc;
        end
      end
      ST_LOCKOUT: begin
        if (lcnt_q <= LOCK_LAST) begin
          state_d = ST_IDLE;
          fail_d  = '0;
          lcnt_d  = '0;
        end else begin
          lcnt_d = lcnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fail_q  <= '0;
      lcnt_q  <= '0;
      err_q   <= 1'b0;
`ifdef ELELOCK_PROG_EN
      secret_q <= SECRET;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      lcnt_q  <= lcnt_d;
      err_q   <= err_d;
`ifdef ELELOCK_PROG_EN
      secret_q <= secret_d;
`endif
    end
  end

  // Entry buffer; only meaningful once cnt_q reaches DIGITS, so no reset
  always_ff @(posedge clk) begin
    code_q <= code_d;
  end

  assign lock       = (state_q != ST_OPEN);
  assign locked_out = (state_q == ST_LOCKOUT);
  assign err        = err_q;
  assign digit_cnt  = cnt_q;

endmodule

// File: tb/tb_elelock_multi.sv
// Self-checking bench for elelock_multi with a queue-based reference model.
// Define ELELOCK_PROG_EN to also exercise secret re-programming.
module tb_elelock_multi;

  localparam int          DIGITS   = 4;
  localparam logic [15:0] SECRET   = 16'h5963;
  localparam int          MAX_FAIL = 3;
  localparam int          LOCKOUT  = 1000;
  localparam int          CW       = $clog2(DIGITS + 1);
`ifdef ELELOCK_PROG_EN
  localparam bit          PROG_EN  = 1'b1;
`else
  localparam bit          PROG_EN  = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [9:0]    tenkey = '0;
  logic          enter = 1'b0;
  logic          close = 1'b0;
`ifdef ELELOCK_PROG_EN
  logic          prog = 1'b0;
`endif
  logic          lock;
  logic          err;
  logic          locked_out;
  logic [CW-1:0] digit_cnt;

  int checks = 0;
  int errors = 0;

  elelock_multi #(
    .DIGITS(DIGITS), .SECRET(SECRET), .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYCLES(LOCKOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tenkey     (tenkey),
    .enter      (enter),
    .close      (close),
`ifdef ELELOCK_PROG_EN
    .prog       (prog),
`endif
    .lock       (lock),
    .err        (err),
    .locked_out (locked_out),
    .digit_cnt  (digit_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mstate: 0 locked/collecting, 1 open, 2 lockout
  int          mstate;
  int          mbuf[$];
  int          mfail;
  int          mrem;
  bit          m_err;
  logic [9:0]  m_prev_tk;
  bit          m_pend;
  int          m_pdig;
  logic [15:0] m_secret;

  function automatic logic [15:0] buf_value();
    logic [15:0] v = '0;
    foreach (mbuf[i]) v = (v << 4) | 16'(mbuf[i]);
    return v;
  endfunction

  function automatic void push_digit(int d);
    mbuf.push_back(d);
    if (mbuf.size() > DIGITS) void'(mbuf.pop_front());
  endfunction

  // Apply one clock cycle of inputs to the model
  function automatic void model_step(logic [9:0] tk, bit en, bit cl, bit pg, bit rs);
    bit press_now;
    int pdig;
    if (rs) begin
      mstate = 0; mbuf.delete(); mfail = 0; mrem = 0; m_err = 0;
      m_prev_tk = '1; m_pend = 0; m_pdig = 0; m_secret = SECRET;
      return;
    end
    press_now = m_pend;
    pdig      = m_pdig;
    // A keypad press is seen by the lock one cycle after it is sampled
    m_pend    = ($countones(tk) == 1) && (m_prev_tk == '0);
    m_pdig    = $clog2(tk);
    m_prev_tk = tk;
    m_err     = 0;
    case (mstate)
      0: begin
        if (cl) mbuf.delete();
        else if (en) begin
          if (mbuf.size() == DIGITS && buf_value() == m_secret) begin
            mstate = 1; mfail = 0;
          end else begin
            m_err = 1; mfail++;
            if (mfail == MAX_FAIL) begin mstate = 2; mrem = LOCKOUT; end
          end
          mbuf.delete();
        end else if (press_now) push_digit(pdig);
      end
      1: begin
        if (cl) begin mstate = 0; mbuf.delete(); end
        else if (PROG_EN && pg) begin
          if (mbuf.size() == DIGITS) m_secret = buf_value();
          mbuf.delete();
        end else if (!en && press_now) push_digit(pdig);
      end
      default: begin
        mrem--;
        if (mrem == 0) begin mstate = 0; mfail = 0; end
      end
    endcase
  endfunction

  function automatic logic [CW+2:0] exp_vec();
    return {mstate != 1, m_err, mstate == 2, CW'(mbuf.size())};
  endfunction

  wire [CW+2:0] dut_vec = {lock, err, locked_out, digit_cnt};

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [9:0] tk, input bit en, input bit cl, input bit pg, input bit rs);
    tenkey = tk; enter = en; close = cl; reset = rs;
`ifdef ELELOCK_PROG_EN
    prog = pg;
`endif
    model_step(tk, en, cl, pg, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int d);
    step(10'(1 << d), 0, 0, 0, 0);
    step('0, 0, 0, 0, 0);
  endtask

  task automatic key_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(int'((c >> (4 * i)) & 16'hF));
  endtask

  task automatic do_enter();
    step('0, 1, 0, 0, 0);
  endtask

  task automatic do_close();
    step('0, 0, 1, 0, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step(10'(1 << 5), 0, 0, 0, 1);
    step(10'(1 << 5), 0, 0, 0, 1);
    checks++;
    if (dut_vec !== {1'b1, 1'b0, 1'b0, CW'(0)}) begin
      errors++; $display("FAIL reset_values got=%b want=%b", dut_vec, {1'b1, 1'b0, 1'b0, CW'(0)});
    end
    for (int i = 0; i < 3; i++) step(10'(1 << 5), 0, 0, 0, 0);
    step('0, 0, 0, 0, 0);
    checks++;
    if (digit_cnt !== CW'(0)) begin
      errors++; $display("FAIL held_at_reset digit_cnt got=%0d want=0", digit_cnt);
    end
  endtask

  task automatic test_open();
    key_code(SECRET);
    checks++;
    if (digit_cnt !== CW'(4)) begin
      errors++; $display("FAIL open_cnt got=%0d want=4", digit_cnt);
    end
    checks++;
    if (lock !== 1'b1) begin errors++; $display("FAIL open_before_enter lock got=%b want=1", lock); end
    do_enter();
    checks++;
    if ({lock, err} !== 2'b00) begin
      errors++; $display("FAIL open_enter lock,err got=%b want=00", {lock, err});
    end
    do_enter();
    checks++;
    if ({lock, err} !== 2'b00) begin
      errors++; $display("FAIL open_reenter lock,err got=%b want=00", {lock, err});
    end
    do_close();
    checks++;
    if ({lock, digit_cnt} !== {1'b1, CW'(0)}) begin
      errors++; $display("FAIL open_close lock,cnt got=%b want=%b", {lock, digit_cnt}, {1'b1, CW'(0)});
    end
  endtask

  task automatic test_fail_then_open();
    press(5); press(9); press(6);
    do_enter();
    checks++;
    if ({lock, err, locked_out} !== 3'b110) begin
      errors++; $display("FAIL short_code lock,err,lo got=%b want=110", {lock, err, locked_out});
    end
    step('0, 0, 0, 0, 0);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_one_cycle got=%b want=0", err); end
    key_code(SECRET);
    do_enter();
    checks++;
    if ({lock, err} !== 2'b00) begin
      errors++; $display("FAIL open_after_fail lock,err got=%b want=00", {lock, err});
    end
    do_close();
  endtask

  task automatic test_lockout();
    int n;
    int opened;
    logic [9:0] tk;
    int code_d[4] = '{5, 9, 6, 3};
    for (int k = 0; k < MAX_FAIL; k++) begin
      key_code(16'h1234);
      do_enter();
    end
    checks++;
    if ({err, locked_out, lock} !== 3'b111) begin
      errors++; $display("FAIL lockout_entry err,lo,lock got=%b want=111", {err, locked_out, lock});
    end
    n = 1; opened = 0;
    for (int c = 0; c < LOCKOUT + 100; c++) begin
      tk = (c < 8 && c % 2 == 0) ? 10'(1 << code_d[c / 2]) : 10'd0;
      step(tk, c == 8, c == 20, 0, 0);
      if (lock !== 1'b1) opened++;
      if (locked_out !== 1'b1) break;
      n++;
    end
    checks++;
    if (n !== LOCKOUT) begin errors++; $display("FAIL lockout_len got=%0d want=%0d", n, LOCKOUT); end
    checks++;
    if (opened !== 0) begin errors++; $display("FAIL lockout_opened got=%0d want=0", opened); end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL lockout_exit got=%b want=%b", dut_vec, exp_vec());
    end
    key_code(SECRET);
    do_enter();
    checks++;
    if (lock !== 1'b0) begin errors++; $display("FAIL open_after_lockout lock got=%b want=0", lock); end
    do_close();
  endtask

  task automatic test_keys();
    do_close();
    for (int i = 0; i < 5; i++) step(10'(1 << 7), 0, 0, 0, 0);
    step('0, 0, 0, 0, 0);
    checks++;
    if (digit_cnt !== CW'(1)) begin errors++; $display("FAIL held_key cnt got=%0d want=1", digit_cnt); end
    step(10'b0000100001, 0, 0, 0, 0);
    step('0, 0, 0, 0, 0);
    checks++;
    if (digit_cnt !== CW'(1)) begin errors++; $display("FAIL multi_hot cnt got=%0d want=1", digit_cnt); end
    // The press reaches the lock in the same cycle as the enter strobe
    step(10'(1 << 2), 0, 0, 0, 0);
    step('0, 1, 0, 0, 0);
    checks++;
    if ({err, digit_cnt} !== {1'b1, CW'(0)}) begin
      errors++; $display("FAIL press_with_enter err,cnt got=%b want=%b", {err, digit_cnt}, {1'b1, CW'(0)});
    end
    press(4);
    step('0, 1, 1, 0, 0);
    checks++;
    if ({err, digit_cnt} !== {1'b0, CW'(0)}) begin
      errors++; $display("FAIL close_enter err,cnt got=%b want=%b", {err, digit_cnt}, {1'b0, CW'(0)});
    end
    key_code(SECRET);
    do_enter();
    step(10'(1 << 8), 0, 0, 0, 0);
    step('0, 1, 0, 0, 0);
    checks++;
    if ({lock, err, digit_cnt} !== {1'b0, 1'b0, CW'(0)}) begin
      errors++; $display("FAIL open_press_enter got=%b want=%b", {lock, err, digit_cnt}, {1'b0, 1'b0, CW'(0)});
    end
    do_close();
  endtask

`ifdef ELELOCK_PROG_EN
  task automatic test_prog();
    key_code(SECRET);
    do_enter();
    key_code(16'h1234);
    step('0, 0, 0, 1, 0);
    checks++;
    if ({lock, digit_cnt} !== {1'b0, CW'(0)}) begin
      errors++; $display("FAIL prog_clear got=%b want=%b", {lock, digit_cnt}, {1'b0, CW'(0)});
    end
    do_close();
    key_code(16'h1234);
    do_enter();
    checks++;
    if ({lock, err} !== 2'b00) begin errors++; $display("FAIL new_code lock,err got=%b want=00", {lock, err}); end
    do_close();
    key_code(SECRET);
    do_enter();
    checks++;
    if ({lock, err} !== 2'b11) begin errors++; $display("FAIL old_code lock,err got=%b want=11", {lock, err}); end
    step('0, 0, 0, 0, 1);
    key_code(SECRET);
    do_enter();
    checks++;
    if (lock !== 1'b0) begin errors++; $display("FAIL secret_restored lock got=%b want=0", lock); end
    do_close();
  endtask
`endif

  task automatic test_reset_mid();
    press(5); press(9);
    step('0, 0, 0, 0, 1);
    checks++;
    if (dut_vec !== {1'b1, 1'b0, 1'b0, CW'(0)}) begin
      errors++; $display("FAIL reset_mid_entry got=%b want=%b", dut_vec, {1'b1, 1'b0, 1'b0, CW'(0)});
    end
    for (int k = 0; k < MAX_FAIL; k++) do_enter();
    for (int i = 0; i < 10; i++) step('0, 0, 0, 0, 0);
    step('0, 0, 0, 0, 1);
    checks++;
    if (dut_vec !== {1'b1, 1'b0, 1'b0, CW'(0)}) begin
      errors++; $display("FAIL reset_in_lockout got=%b want=%b", dut_vec, {1'b1, 1'b0, 1'b0, CW'(0)});
    end
    for (int k = 0; k < MAX_FAIL - 1; k++) do_enter();
    checks++;
    if (locked_out !== 1'b0) begin errors++; $display("FAIL fail_cnt_cleared lo got=%b want=0", locked_out); end
    do_enter();
    checks++;
    if (locked_out !== 1'b1) begin errors++; $display("FAIL fail_cnt_relock lo got=%b want=1", locked_out); end
    step('0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    logic [9:0] tk;
    int r;
    int shown = 0;
    for (int c = 0; c < 6000; c++) begin
      r = $urandom_range(0, 9);
      if (r < 5)       tk = '0;
      else if (r < 8)  tk = 10'(1 << $urandom_range(0, 9));
      else if (r == 8) tk = 10'(1 << ((SECRET >> (4 * $urandom_range(0, 3))) & 16'hF));
      else             tk = 10'($urandom);
      step(tk, $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 499) == 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        if (shown < 10) $display("FAIL random cyc=%0d {lock,err,lo,cnt} got=%b want=%b", c, dut_vec, exp_vec());
        shown++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_open();
    test_fail_then_open();
    test_lockout();
    test_keys();
`ifdef ELELOCK_PROG_EN
    test_prog();
`endif
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
